// File: rtl/wakeup_pipe_if.sv
// wakeup_pipe_if: issue-port ops in, registered execute ops and wakeup broadcast lanes out
interface wakeup_pipe_if #(
  parameter int WIDTH_REG = 5,
  parameter int WIDTH_TAG = 5,
  parameter int WIDTH_BRM = 3,
  parameter int WIDTH_O   = 7 + WIDTH_BRM + WIDTH_TAG + 2 + 3 * WIDTH_REG
);
  logic [WIDTH_O-1:0]        i_inst1;
  logic [WIDTH_O-1:0]        i_inst2;
  logic                      i_valid1;
  logic                      i_valid2;
  logic [2**WIDTH_BRM-1:0]   i_brkill;
  logic                      i_en;
  logic [WIDTH_O-1:0]        o_ex1;
  logic [WIDTH_O-1:0]        o_ex2;
  logic [1:0]                o_ex_valid;
  logic [4*WIDTH_REG-1:0]    o_wdest4x;
  modport master (
    output i_inst1, i_inst2, i_valid1, i_valid2, i_brkill, i_en,
    input  o_ex1, o_ex2, o_ex_valid, o_wdest4x
  );
  modport slave (
    input  i_inst1, i_inst2, i_valid1, i_valid2, i_brkill, i_en,
    output o_ex1, o_ex2, o_ex_valid, o_wdest4x
  );
endinterface

// File: rtl/wakeup_pipe.sv
// wakeup_pipe: issue-to-execute register stage with short (ALU) and long (MUL/LD) wakeup lanes
module wakeup_pipe #(
  parameter int WIDTH_REG = 5,
  parameter int WIDTH_TAG = 5,
  parameter int WIDTH_BRM = 3,
  parameter int WIDTH_O   = 7 + WIDTH_BRM + WIDTH_TAG + 2 + 3 * WIDTH_REG
) (
  input logic          i_clk,
  input logic          i_rst,
  wakeup_pipe_if.slave bus
);
  localparam int TY_LSB  = 3 * WIDTH_REG;
  localparam int RD_LSB  = 2 * WIDTH_REG;
  localparam int BRT_LSB = TY_LSB + 2 + WIDTH_TAG;
  typedef enum logic [1:0] {TY_ALU, TY_MUL, TY_LD, TY_BR} ty_e;
  typedef struct packed {
    logic                 v;
    logic [WIDTH_BRM-1:0] brt;
    logic [WIDTH_REG-1:0] rd;
  } stg_t;
  logic [1:0][WIDTH_O-1:0]   inst;
  logic [1:0]                vld;
  logic [1:0][WIDTH_O-1:0]   ex;
  logic [1:0]                exv;
  logic [1:0][WIDTH_REG-1:0] lane_s;
  logic [1:0][WIDTH_REG-1:0] lane_l;
  function automatic stg_t kill(input stg_t s, input logic [2**WIDTH_BRM-1:0] k);
    kill   = s;
    kill.v = s.v && !k[s.brt];
  endfunction
  assign inst = {bus.i_inst2, bus.i_inst1};
  assign vld  = {bus.i_valid2, bus.i_valid1};
  for (genvar p = 0; p < 2; p++) begin : g_port
    ty_e                  ty;
    logic [WIDTH_BRM-1:0] brt;
    logic                 acc;
    stg_t                 in_s;
    logic [WIDTH_O-1:0]   ex_q, ex_d;
    logic                 exv_q, exv_d;
    stg_t [2:0]           s_q, s_d;
    assign ty   = ty_e'(inst[p][TY_LSB +: 2]);
    assign brt  = inst[p][BRT_LSB +: WIDTH_BRM];
    assign acc  = bus.i_en && vld[p] && !bus.i_brkill[brt];
    assign in_s = '{v: acc && (ty == TY_MUL || ty == TY_LD), brt: brt, rd: inst[p][RD_LSB +: WIDTH_REG]};
    // accept or hold the op, advance the long lane on enable, then drop anything whose branch is killed
    always_comb begin
      ex_d   = acc ? inst[p] : ex_q;
      exv_d  = (bus.i_en ? acc : exv_q) && !bus.i_brkill[ex_d[BRT_LSB +: WIDTH_BRM]];
      s_d[0] = kill(bus.i_en ? in_s : s_q[0], bus.i_brkill);
      s_d[1] = kill(bus.i_en ? s_q[0] : s_q[1], bus.i_brkill);
      s_d[2] = kill(bus.i_en ? s_q[1] : s_q[2], bus.i_brkill);
    end
    // state registers; reset discards every in-flight op at once
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        ex_q  <= '0;
        exv_q <= 1'b0;
        s_q   <= '0;
      end else begin
        ex_q  <= ex_d;
        exv_q <= exv_d;
        s_q   <= s_d;
      end
    end
    assign ex[p]     = ex_q;
    assign exv[p]    = exv_q;
    assign lane_s[p] = (exv_q && ex_q[TY_LSB +: 2] == TY_ALU) ? ex_q[RD_LSB +: WIDTH_REG] : '0;
    assign lane_l[p] = s_q[2].v ? s_q[2].rd : '0;
  end
  assign bus.o_ex1      = ex[0];
  assign bus.o_ex2      = ex[1];
  assign bus.o_ex_valid = exv;
  assign bus.o_wdest4x  = {lane_l[1], lane_l[0], lane_s[1], lane_s[0]};
endmodule

// File: tb/tb_wakeup_pipe.sv
// tb_wakeup_pipe: scenario tasks with a per-cycle expected-output scoreboard queue
module tb_wakeup_pipe;
  localparam int R = 5;
  localparam int T = 5;
  localparam int B = 3;
  localparam int O = 7 + B + T + 2 + 3 * R;
  localparam logic [1:0] ALU = 2'b00, MUL = 2'b01, LD = 2'b10, BR = 2'b11;
  typedef struct packed {
    logic [4*R-1:0] wd;
    logic [1:0]     v;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t exp_q[$];
  exp_t e;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  wakeup_pipe_if #(.WIDTH_REG(R), .WIDTH_TAG(T), .WIDTH_BRM(B), .WIDTH_O(O)) bus ();
  wakeup_pipe #(.WIDTH_REG(R), .WIDTH_TAG(T), .WIDTH_BRM(B), .WIDTH_O(O)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );
  function automatic logic [O-1:0] mk(input logic [1:0] ty, input logic [R-1:0] rd, input logic [B-1:0] brt);
    return {7'h13, brt, {T{1'b0}}, ty, rd, {R{1'b0}}, {R{1'b1}}};
  endfunction
  function automatic logic [4*R-1:0] wd(input logic [R-1:0] l3, l2, l1, l0);
    return {l3, l2, l1, l0};
  endfunction
  function automatic exp_t xp(input logic [4*R-1:0] w, input logic [1:0] v);
    xp.wd = w;
    xp.v  = v;
  endfunction
  task automatic drv(input logic en, input logic v1, input logic [O-1:0] i1,
                     input logic v2, input logic [O-1:0] i2, input logic [7:0] k);
    bus.i_en     = en;
    bus.i_valid1 = v1;
    bus.i_inst1  = i1;
    bus.i_valid2 = v2;
    bus.i_inst2  = i2;
    bus.i_brkill = k;
  endtask
  task automatic idle();
    drv(1'b1, 1'b0, '0, 1'b0, '0, 8'h00);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    #2;
    n_cmp++; if (bus.o_ex_valid !== 2'b00) begin n_err++; $display("FAIL reset ex_valid got %b exp 00", bus.o_ex_valid); end
    n_cmp++; if (bus.o_ex1 !== '0) begin n_err++; $display("FAIL reset ex1 got %h exp 0", bus.o_ex1); end
    n_cmp++; if (bus.o_ex2 !== '0) begin n_err++; $display("FAIL reset ex2 got %h exp 0", bus.o_ex2); end
    n_cmp++; if (bus.o_wdest4x !== '0) begin n_err++; $display("FAIL reset wdest got %h exp 0", bus.o_wdest4x); end
    #1 rst = 1'b0;
  endtask
  task automatic test_alu_pair();
    exp_q.push_back(xp(wd(0, 0, 9, 7), 2'b11));
    exp_q.push_back(xp('0, 2'b00));
    for (int k = 0; k < 2; k++) begin
      if (k == 0) drv(1'b1, 1'b1, mk(ALU, 7, 0), 1'b1, mk(ALU, 9, 0), 8'h00); else idle();
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (bus.o_wdest4x !== e.wd) begin n_err++; $display("FAIL alu_pair wdest k=%0d got %h exp %h", k, bus.o_wdest4x, e.wd); end
      n_cmp++; if (bus.o_ex_valid !== e.v) begin n_err++; $display("FAIL alu_pair ex_valid k=%0d got %b exp %b", k, bus.o_ex_valid, e.v); end
    end
    n_cmp++; if (bus.o_ex1 !== mk(ALU, 7, 0)) begin n_err++; $display("FAIL alu_pair ex1 hold got %h exp %h", bus.o_ex1, mk(ALU, 7, 0)); end
    n_cmp++; if (bus.o_ex2 !== mk(ALU, 9, 0)) begin n_err++; $display("FAIL alu_pair ex2 hold got %h exp %h", bus.o_ex2, mk(ALU, 9, 0)); end
  endtask
  task automatic test_mul();
    exp_q.push_back(xp('0, 2'b10));
    exp_q.push_back(xp('0, 2'b00));
    exp_q.push_back(xp(wd(12, 0, 0, 0), 2'b00));
    exp_q.push_back(xp('0, 2'b00));
    exp_q.push_back(xp('0, 2'b00));
    for (int k = 0; k < 5; k++) begin
      if (k == 0) drv(1'b1, 1'b0, '0, 1'b1, mk(MUL, 12, 0), 8'h00); else idle();
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (bus.o_wdest4x !== e.wd) begin n_err++; $display("FAIL mul wdest k=%0d got %h exp %h", k, bus.o_wdest4x, e.wd); end
      n_cmp++; if (bus.o_ex_valid !== e.v) begin n_err++; $display("FAIL mul ex_valid k=%0d got %b exp %b", k, bus.o_ex_valid, e.v); end
    end
  endtask
  task automatic test_kill();
    exp_q.push_back(xp('0, 2'b01));
    for (int k = 0; k < 4; k++) exp_q.push_back(xp('0, 2'b00));
    exp_q.push_back(xp('0, 2'b00));
    exp_q.push_back(xp(wd(0, 0, 8, 0), 2'b10));
    exp_q.push_back(xp('0, 2'b00));
    exp_q.push_back(xp('0, 2'b00));
    for (int k = 0; k < 9; k++) begin
      case (k)
        0:       drv(1'b1, 1'b1, mk(LD, 5, 2), 1'b0, '0, 8'h00);
        1:       drv(1'b1, 1'b0, '0, 1'b0, '0, 8'b0000_0100);
        5:       drv(1'b1, 1'b1, mk(ALU, 4, 1), 1'b0, '0, 8'b0000_0010);
        6:       drv(1'b1, 1'b0, '0, 1'b1, mk(ALU, 8, 5), 8'h00);
        7:       drv(1'b0, 1'b0, '0, 1'b0, '0, 8'b0010_0000);
        default: idle();
      endcase
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (bus.o_wdest4x !== e.wd) begin n_err++; $display("FAIL kill wdest k=%0d got %h exp %h", k, bus.o_wdest4x, e.wd); end
      n_cmp++; if (bus.o_ex_valid !== e.v) begin n_err++; $display("FAIL kill ex_valid k=%0d got %b exp %b", k, bus.o_ex_valid, e.v); end
    end
  endtask
  task automatic test_freeze();
    exp_q.push_back(xp(wd(0, 0, 3, 0), 2'b11));
    exp_q.push_back(xp(wd(0, 0, 3, 0), 2'b11));
    exp_q.push_back(xp(wd(0, 0, 3, 0), 2'b11));
    exp_q.push_back(xp('0, 2'b00));
    exp_q.push_back(xp(wd(0, 20, 0, 0), 2'b00));
    exp_q.push_back(xp('0, 2'b00));
    for (int k = 0; k < 6; k++) begin
      if (k == 0) drv(1'b1, 1'b1, mk(MUL, 20, 0), 1'b1, mk(ALU, 3, 0), 8'h00);
      else if (k < 3) drv(1'b0, 1'b1, mk(ALU, 11, 0), 1'b1, mk(LD, 13, 0), 8'h00);
      else idle();
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (bus.o_wdest4x !== e.wd) begin n_err++; $display("FAIL freeze wdest k=%0d got %h exp %h", k, bus.o_wdest4x, e.wd); end
      n_cmp++; if (bus.o_ex_valid !== e.v) begin n_err++; $display("FAIL freeze ex_valid k=%0d got %b exp %b", k, bus.o_ex_valid, e.v); end
    end
    n_cmp++; if (bus.o_ex1 !== mk(MUL, 20, 0)) begin n_err++; $display("FAIL freeze ex1 got %h exp %h", bus.o_ex1, mk(MUL, 20, 0)); end
  endtask
  task automatic test_branch();
    exp_q.push_back(xp('0, 2'b11));
    for (int k = 0; k < 3; k++) exp_q.push_back(xp('0, 2'b00));
    for (int k = 0; k < 4; k++) begin
      if (k == 0) drv(1'b1, 1'b1, mk(BR, 3, 0), 1'b1, mk(ALU, 0, 0), 8'h00); else idle();
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (bus.o_wdest4x !== e.wd) begin n_err++; $display("FAIL branch wdest k=%0d got %h exp %h", k, bus.o_wdest4x, e.wd); end
      n_cmp++; if (bus.o_ex_valid !== e.v) begin n_err++; $display("FAIL branch ex_valid k=%0d got %b exp %b", k, bus.o_ex_valid, e.v); end
    end
  endtask
  task automatic test_reset_mid();
    exp_q.push_back(xp('0, 2'b01));
    exp_q.push_back(xp('0, 2'b00));
    for (int k = 0; k < 2; k++) begin
      if (k == 0) drv(1'b1, 1'b1, mk(LD, 6, 0), 1'b0, '0, 8'h00); else idle();
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (bus.o_ex_valid !== e.v) begin n_err++; $display("FAIL rst_mid pre ex_valid k=%0d got %b exp %b", k, bus.o_ex_valid, e.v); end
    end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.o_ex1 !== '0) begin n_err++; $display("FAIL rst_mid ex1 got %h exp 0", bus.o_ex1); end
    n_cmp++; if (bus.o_wdest4x !== '0) begin n_err++; $display("FAIL rst_mid wdest got %h exp 0", bus.o_wdest4x); end
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) exp_q.push_back(xp('0, 2'b00));
    for (int k = 0; k < 4; k++) begin
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (bus.o_wdest4x !== e.wd) begin n_err++; $display("FAIL rst_mid post wdest k=%0d got %h exp %h", k, bus.o_wdest4x, e.wd); end
    end
  endtask
  task automatic test_back_to_back();
    logic [R-1:0] a[8];
    logic [R-1:0] b[8];
    logic [R-1:0] l0, l3;
    for (int k = 0; k < 8; k++) begin
      a[k] = R'($urandom_range(1, 31));
      b[k] = R'($urandom_range(1, 31));
    end
    for (int j = 0; j < 11; j++) begin
      l0 = (j < 8) ? a[j] : '0;
      l3 = (j >= 2 && j < 10) ? b[j-2] : '0;
      exp_q.push_back(xp(wd(l3, 0, 0, l0), (j < 8) ? 2'b11 : 2'b00));
    end
    for (int j = 0; j < 11; j++) begin
      if (j < 8) drv(1'b1, 1'b1, mk(ALU, a[j], 3'(j)), 1'b1, mk(LD, b[j], 3'(j)), 8'h00); else idle();
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (bus.o_wdest4x !== e.wd) begin n_err++; $display("FAIL b2b wdest j=%0d got %h exp %h", j, bus.o_wdest4x, e.wd); end
      n_cmp++; if (bus.o_ex_valid !== e.v) begin n_err++; $display("FAIL b2b ex_valid j=%0d got %b exp %b", j, bus.o_ex_valid, e.v); end
    end
  endtask
  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    idle();
    test_reset();
    test_alu_pair();
    test_mul();
    test_kill();
    test_freeze();
    test_branch();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
